// File: rtl/tri_mux_bank_pipe.sv
// ============================================================================
// tri_mux_bank_pipe : registered triangular mux bank with valid/ready skid pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module tri_mux_bank_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 64,
  parameter int SEL_WIDTH  = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_sel_we,
  input  logic [LANES*SEL_WIDTH-1:0]          cfg_sel,
  output logic                                cfg_err,
  input  logic                                err_clr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*(LANES+1)*DATA_WIDTH-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*DATA_WIDTH-1:0]         out_data,
  output logic [CNT_WIDTH-1:0]                beat_cnt
);

  logic [LANES-1:0]            w_load_bad;
  logic [LANES*DATA_WIDTH-1:0] w_mux;
  logic [LANES*DATA_WIDTH-1:0] r_main;
  logic [LANES*DATA_WIDTH-1:0] r_skid;
  logic                        r_main_valid;
  logic                        r_skid_valid;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic                        r_err;
  logic                        w_accept;
  logic                        w_unused_data;

  // Inputs beyond a lane's legal range never reach the mux.
  assign w_unused_data = ^in_data;

  assign in_ready  = !r_skid_valid;
  assign w_accept  = in_valid && !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main;
  assign beat_cnt  = r_cnt;
  assign cfg_err   = r_err;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int                   C_NUM_IN = LANES + 1 - i;
    localparam logic [SEL_WIDTH-1:0] C_MAX    = SEL_WIDTH'(LANES - i);

    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  r_bad;
    logic [DATA_WIDTH-1:0] w_lane;

    assign w_load_bad[i] = cfg_sel[i*SEL_WIDTH +: SEL_WIDTH] > C_MAX;

    // Legality is latched at load so the datapath only sees a kill bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sel <= '0;
        r_bad <= 1'b0;
      end else if (cfg_sel_we) begin
        r_sel <= cfg_sel[i*SEL_WIDTH +: SEL_WIDTH];
        r_bad <= w_load_bad[i];
      end
    end

    always_comb begin
      w_lane = '0;
      if (!r_bad) begin
        for (int j = 0; j < C_NUM_IN; j++) begin
          if (r_sel == SEL_WIDTH'(j)) begin
            w_lane = in_data[(i*(LANES+1)+j)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end

    assign w_mux[i*DATA_WIDTH +: DATA_WIDTH] = w_lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (cfg_sel_we && (|w_load_bad)) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Main/skid pair: skid only fills while main is stalled, and refills main first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || out_ready) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_mux;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_mux;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_main_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tri_mux_bank_pipe.sv
// Directed bench for tri_mux_bank_pipe at LANES=4, DATA_WIDTH=8, CNT_WIDTH=4.
`default_nettype none

module tb_tri_mux_bank_pipe;
  localparam int DW = 8;
  localparam int LN = 4;
  localparam int SW = 3;
  localparam int CW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    cfg_sel_we;
  logic [LN*SW-1:0]        cfg_sel;
  logic                    cfg_err;
  logic                    err_clr;
  logic                    in_valid;
  logic                    in_ready;
  logic [LN*(LN+1)*DW-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LN*DW-1:0]        out_data;
  logic [CW-1:0]           beat_cnt;

  int errors = 0;
  int checks = 0;

  tri_mux_bank_pipe #(.DATA_WIDTH(DW), .LANES(LN), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_sel_we(cfg_sel_we), .cfg_sel(cfg_sel),
    .cfg_err(cfg_err), .err_clr(err_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Element value for beat tag t, lane i, input j; tag bits sit in bits 3, 7:6.
  function automatic logic [7:0] elem(int t, int i, int j);
    return 8'(16*i + j + 8*(t & 1) + 64*((t >> 1) & 3));
  endfunction

  function automatic logic [LN*(LN+1)*DW-1:0] mk(int t);
    logic [LN*(LN+1)*DW-1:0] d;
    d = '0;
    for (int i = 0; i < LN; i++)
      for (int j = 0; j <= LN; j++)
        d[(i*(LN+1)+j)*DW +: DW] = elem(t, i, j);
    return d;
  endfunction

  // s3..s0 are lane selects; a negative select means the lane is killed.
  function automatic logic [LN*DW-1:0] ex(int t, int s3, int s2, int s1, int s0);
    int s [LN];
    logic [LN*DW-1:0] w;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    w = '0;
    for (int i = 0; i < LN; i++)
      w[i*DW +: DW] = (s[i] < 0) ? 8'h00 : elem(t, i, s[i]);
    return w;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_sel_we = 1'b0; cfg_sel = '0; err_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    rst_n = 1'b1;

    // Steady stream with selects {lane3..lane0} = {1,2,1,0}
    cfg_sel = {3'd1, 3'd2, 3'd1, 3'd0}; cfg_sel_we = 1'b1;
    tick();
    cfg_sel_we = 1'b0; in_valid = 1'b1; in_data = mk(0);
    tick();
    chk("s0_valid", 64'(out_valid), 64'd1);
    chk("s0_data", 64'(out_data), 64'h31221100);
    chk("s0_cnt", 64'(beat_cnt), 64'd0);
    in_data = mk(1);
    tick();
    chk("s1_data", 64'(out_data), 64'h392A1908);
    chk("s1_cnt", 64'(beat_cnt), 64'd1);
    in_data = mk(2);
    tick();
    chk("s2_data", 64'(out_data), 64'h71625140);
    chk("s2_cnt", 64'(beat_cnt), 64'd2);

    // Backpressure: beat 2 held in main, beat 3 into skid
    out_ready = 1'b0; in_data = mk(3);
    tick();
    chk("bp1_data", 64'(out_data), 64'h71625140);
    chk("bp1_in_ready", 64'(in_ready), 64'd0);
    in_data = mk(4);
    tick();
    chk("bp2_data", 64'(out_data), 64'h71625140);
    chk("bp2_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("bp3_cnt", 64'(beat_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("rel1_data", 64'(out_data), 64'(ex(3, 1, 2, 1, 0)));
    chk("rel1_in_ready", 64'(in_ready), 64'd1);
    chk("rel1_cnt", 64'(beat_cnt), 64'd3);
    tick();
    chk("rel2_data", 64'(out_data), 64'(ex(4, 1, 2, 1, 0)));
    in_valid = 1'b0;
    tick();
    chk("rel3_valid", 64'(out_valid), 64'd0);
    chk("rel3_cnt", 64'(beat_cnt), 64'd5);

    // Illegal lane-3 select with a same-cycle clear: set wins
    cfg_sel = {3'd2, 3'd2, 3'd1, 3'd0}; cfg_sel_we = 1'b1; err_clr = 1'b1;
    tick();
    chk("ill_err_set", 64'(cfg_err), 64'd1);
    cfg_sel_we = 1'b0; err_clr = 1'b0; in_valid = 1'b1; in_data = mk(5);
    tick();
    chk("ill_data", 64'(out_data), 64'(ex(5, -1, 2, 1, 0)));
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    chk("ill_err_clr", 64'(cfg_err), 64'd0);
    err_clr = 1'b0; in_valid = 1'b1; in_data = mk(6);
    tick();
    chk("ill_still_zero", 64'(out_data), 64'(ex(6, -1, 2, 1, 0)));

    // Reload legal selects on the same edge a beat is accepted
    cfg_sel = {3'd0, 3'd1, 3'd1, 3'd0}; cfg_sel_we = 1'b1; in_data = mk(7);
    tick();
    chk("cfgacc_old", 64'(out_data), 64'(ex(7, -1, 2, 1, 0)));
    cfg_sel_we = 1'b0; in_data = mk(0);
    tick();
    chk("cfgacc_new", 64'(out_data), 64'h30211100);
    in_valid = 1'b0;
    tick();
    chk("cnt_9", 64'(beat_cnt), 64'd9);

    // Counter wrap: 8 more delivered beats reach 17 total
    in_valid = 1'b1; in_data = mk(1);
    for (int k = 0; k < 8; k++) tick();
    chk("cnt_wrap0", 64'(beat_cnt), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("cnt_wrap1", 64'(beat_cnt), 64'd1);

    // Fill main and skid, then reset asynchronously
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(1);
    tick(); tick();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_cnt", 64'(beat_cnt), 64'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1; in_data = mk(0);
    tick();
    chk("post_rst_data", 64'(out_data), 64'h30201000);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
